// File: rtl/addsub_pkg.sv
// Shared types and constants for the multi-cycle add/subtract sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the {z,n,v,c} condition-code nibble.
  localparam int CC_Z = 3;
  localparam int CC_N = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  // Width of the shared adder slice.
  localparam int NIB_W = 4;

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice. b arrives already inverted for
// subtraction; cin is kept separate so one slice can be reused per nibble.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Flat lookahead equations: every carry depends only on p, g and cin.
  always_comb begin
    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
  end

  assign sum  = w_p ^ w_c[3:0];
  assign cout = w_c[4];
  assign c3   = w_c[3];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: one 4-bit lookahead slice is stepped
// LSB-first over WIDTH/4 cycles to build a WIDTH-bit result plus {z,n,v,c}.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | in_ready=1, waiting for in_valid
//   RUN   | one nibble per cycle, r_idx selects the nibble
//   DONE  | out_valid=1, result/cc held until out_ready or abort
//
// WIDTH must be a multiple of 4 and at least 8.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       cc,
  output logic             busy
);

  localparam int NIB_CNT = WIDTH / NIB_W;
  localparam int IDXW    = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB_CNT - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_zacc;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_cc;
  logic             r_out_valid;
  logic             r_busy;

  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_sum;
  logic             w_cout;
  logic             w_c3;
  logic             w_sum_zero;

  // Operand nibble select; b is inverted here so the slice stays a pure adder.
  assign w_a_nib    = r_a[r_idx*NIB_W +: NIB_W];
  assign w_b_nib    = r_b[r_idx*NIB_W +: NIB_W] ^ {NIB_W{r_sub}};
  assign w_sum_zero = (w_sum == '0);

  cla4_slice u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .c3   (w_c3)
  );

  // Sequencer FSM with registered outputs; abort outranks out_ready in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_result    <= '0;
      r_cc        <= 4'b0000;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_idx   <= '0;
            r_carry <= sub;
            r_zacc  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_result[r_idx*NIB_W +: NIB_W] <= w_sum;
            r_carry <= w_cout;
            r_zacc  <= r_zacc & w_sum_zero;
            if (r_idx == IDX_LAST) begin
              r_cc[CC_C]  <= w_cout;
              r_cc[CC_V]  <= w_cout ^ w_c3;
              r_cc[CC_N]  <= w_sum[NIB_W-1];
              r_cc[CC_Z]  <= r_zacc & w_sum_zero;
              r_idx       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (abort || out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // in_ready decodes state only, so out_ready never reaches it combinationally.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;
  assign cc        = r_cc;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl (WIDTH=16) with hand-computed results.
module tb_addsub_seq_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       cc;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  addsub_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cc        (cc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one operation and hold it until the accepting edge.
  task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic op_sub);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    sub      = op_sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    sub      = 1'($urandom);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  // Count edges after the accepting edge until out_valid appears.
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  // Check result/cc, then let the consumer take it with out_ready high.
  task automatic expect_op(input string tag, input logic [15:0] exp_r, input logic [3:0] exp_cc);
    int lat;
    wait_out(lat);
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_r});
    chk({tag, "_cc"}, {28'd0, cc}, {28'd0, exp_cc});
    @(posedge clk);
    #1;
    chk({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_cc", {28'd0, cc}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    start_op(16'h1234, 16'h4321, 1'b0);
    expect_op("add_1234_4321", 16'h5555, 4'b0000);

    start_op(16'h0005, 16'h0005, 1'b1);
    expect_op("sub_5_5", 16'h0000, 4'b1001);

    start_op(16'h7FFF, 16'h0001, 1'b0);
    expect_op("add_7fff_1", 16'h8000, 4'b0110);

    start_op(16'h0000, 16'h0001, 1'b1);
    expect_op("sub_0_1", 16'hFFFF, 4'b0100);

    // Backpressure with in_valid toggling: nothing may change or be accepted.
    out_ready = 1'b0;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("bp_latency", lat, 32'd4);
    chk("bp_result", {16'd0, result}, 32'h0000);
    chk("bp_cc", {28'd0, cc}, 32'b1001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk);
      #1;
      chk("bp_hold_result", {16'd0, result}, 32'h0000);
      chk("bp_hold_cc", {28'd0, cc}, 32'b1001);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_busy", {31'd0, busy}, 32'd1);
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);

    // Abort while the third nibble (k=2) is being processed.
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end

    start_op(16'h0001, 16'h0001, 1'b0);
    expect_op("add_1_1", 16'h0002, 4'b0000);

    // Abort in DONE outranks out_ready and still drops out_valid.
    out_ready = 1'b0;
    start_op(16'h0002, 16'h0003, 1'b0);
    wait_out(lat);
    chk("done_abort_result", {16'd0, result}, 32'h0005);
    @(negedge clk);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("done_abort_valid", {31'd0, out_valid}, 32'd0);
    chk("done_abort_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of RUN.
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_result", {16'd0, result}, 32'd0);
    chk("arst_cc", {28'd0, cc}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(16'h8000, 16'h0001, 1'b1);
    expect_op("sub_8000_1", 16'h7FFF, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
